// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and state type for the IF-stage fetch sequencer.
package if_fetch_unit_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    localparam int PC_STEP      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack bus; the fetch unit is the master.
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_timeout_ctr.sv
// Stall counter for outstanding memory requests; raises a sticky error at TIMEOUT.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;

    // Saturate at TIMEOUT so a very long stall cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (en_i && !clr_i && (cnt_d == CNT_MAX)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch sequencer: one memory request per instruction, delivers {instr, pc+4}
// downstream and freezes the PC register except on the transfer cycle.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int DATA_W  = FETCH_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch_taken,
    input  logic              id_ready,
    output logic              fetch_freeze,
    if_fetch_unit_if.master   mem,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_err
);

    fetch_state_e      state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pcout_q;

    logic xfer;
    logic tmo_clr;
    logic tmo_en;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(PC_STEP);
    endfunction

    // The PC register may only advance when the held instruction actually leaves.
    assign xfer         = valid_q & id_ready & ~branch_taken;
    assign fetch_freeze = ~xfer;

    // Counter restarts whenever a fresh wait begins (new request, or a flush turning WAIT into DROP).
    assign tmo_clr = ((state_q == ST_IDLE) && !branch_taken) ||
                     ((state_q == ST_WAIT) && !mem.mem_ack && branch_taken);
    assign tmo_en  = ((state_q == ST_WAIT) || (state_q == ST_DROP)) && !mem.mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            pcout_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!branch_taken) begin
                        req_q   <= 1'b1;
                        addr_q  <= pc_in;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_ack) begin
                        req_q <= 1'b0;
                        if (branch_taken) begin
                            state_q <= ST_IDLE;
                        end else begin
                            instr_q <= mem.mem_rdata;
                            pcout_q <= next_pc(addr_q);
                            valid_q <= 1'b1;
                            state_q <= ST_VALID;
                        end
                    end else if (branch_taken) begin
                        state_q <= ST_DROP;
                    end
                end
                // Memory cannot abort, so a flushed request is held until its ack and then discarded.
                ST_DROP: begin
                    if (mem.mem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_VALID: begin
                    if (branch_taken || id_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmo_clr),
        .en_i  (tmo_en),
        .err_o (fetch_err)
    );

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign instr_valid  = valid_q;
    assign instr_out    = instr_q;
    assign pc_out       = pcout_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a transaction-level reference model and per-cycle compare.
module tb_if_fetch_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc_in = '0;
    logic          branch_taken = 1'b0;
    logic          id_ready = 1'b1;
    logic [AW-1:0] br_target = '0;
    logic          fetch_freeze;
    logic          instr_valid;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] pc_out;
    logic          fetch_err;

    if_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    if_fetch_unit #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .branch_taken (branch_taken),
        .id_ready     (id_ready),
        .fetch_freeze (fetch_freeze),
        .mem          (mem.master),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: an outstanding request (possibly flushed), a held instruction, a stall count.
    bit            m_req = 1'b0;
    bit            m_doomed = 1'b0;
    bit            m_valid = 1'b0;
    bit            m_err = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [AW-1:0] m_pcout = '0;
    logic [DW-1:0] m_instr = '0;
    int            m_stall = 0;
    int            m_xfers = 0;
    int            d_xfers = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_req = 1'b0; m_doomed = 1'b0; m_valid = 1'b0; m_err = 1'b0;
            m_addr = '0; m_pcout = '0; m_instr = '0; m_stall = 0;
        end else begin
            if (m_valid && id_ready && !branch_taken) m_xfers++;
            if (m_valid) begin
                if (branch_taken || id_ready) m_valid = 1'b0;
            end else if (m_req) begin
                if (mem.mem_ack) begin
                    m_req = 1'b0;
                    if (!m_doomed && !branch_taken) begin
                        m_valid = 1'b1;
                        m_instr = mem.mem_rdata;
                        m_pcout = m_addr + 32'd4;
                    end
                    m_doomed = 1'b0;
                end else if (branch_taken && !m_doomed) begin
                    m_doomed = 1'b1;
                    m_stall  = 0;
                end else begin
                    m_stall++;
                    if (m_stall >= TO) m_err = 1'b1;
                end
            end else if (!branch_taken) begin
                m_req   = 1'b1;
                m_addr  = pc_in;
                m_stall = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req", mem.mem_req, m_req);
            check("mem_addr", mem.mem_addr, m_addr);
            check("instr_valid", instr_valid, m_valid);
            check("instr_out", instr_out, m_instr);
            check("pc_out", pc_out, m_pcout);
            check("fetch_err", fetch_err, m_err);
            check("fetch_freeze", fetch_freeze, !(m_valid && id_ready && !branch_taken));
            if (!fetch_freeze) d_xfers++;
        end
    end

    // Advance one clock; pc_in follows a PC register driven by branch_taken and fetch_freeze.
    task automatic tick();
        logic [AW-1:0] nxt;
        #2;
        if (rst)               nxt = pc_in;
        else if (branch_taken) nxt = br_target;
        else if (!fetch_freeze) nxt = pc_in + 32'd4;
        else                   nxt = pc_in;
        @(posedge clk);
        #1;
        pc_in = nxt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int x0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;

        // Reset for two cycles
        tick();
        chk_en = 1'b1;
        tick();
        check("rst mem_req", mem.mem_req, 0);
        check("rst instr_valid", instr_valid, 0);
        check("rst fetch_err", fetch_err, 0);
        check("rst pc_out", pc_out, 0);
        rst = 1'b0;

        // Zero-wait fetch from pc 0
        x0 = d_xfers;
        tick();
        check("t1 mem_req C1", mem.mem_req, 1);
        check("t1 mem_addr C1", mem.mem_addr, 32'h0);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h0000_0013;
        #1;
        check("t1 freeze C1", fetch_freeze, 1);
        tick();
        mem.mem_ack = 1'b0;
        #1;
        check("t1 valid C2", instr_valid, 1);
        check("t1 pc_out C2", pc_out, 32'h4);
        check("t1 model pc_out", m_pcout, 32'h4);
        check("t1 instr C2", instr_out, 32'h0000_0013);
        check("t1 freeze C2", fetch_freeze, 0);
        tick();
        check("t1 valid C3", instr_valid, 0);
        check("t1 freeze C3", fetch_freeze, 1);
        check("t1 xfers", d_xfers - x0, 1);

        // Ack delayed three cycles
        x0 = d_xfers;
        tick();
        check("t2 mem_req W1", mem.mem_req, 1);
        check("t2 mem_addr W1", mem.mem_addr, 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2 mem_req held", mem.mem_req, 1);
            check("t2 mem_addr held", mem.mem_addr, 32'h4);
        end
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'hE3A0_1005;
        tick();
        mem.mem_ack = 1'b0;
        check("t2 instr_out", instr_out, 32'hE3A0_1005);
        check("t2 pc_out", pc_out, 32'h8);
        tick();
        check("t2 xfers", d_xfers - x0, 1);

        // Downstream stalls five cycles in VALID
        x0 = d_xfers;
        id_ready = 1'b0;
        tick();
        check("t3 mem_addr", mem.mem_addr, 32'h8);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'hAAAA_5555;
        tick();
        mem.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3 valid held", instr_valid, 1);
            check("t3 instr held", instr_out, 32'hAAAA_5555);
            check("t3 pc_out held", pc_out, 32'hC);
            check("t3 freeze held", fetch_freeze, 1);
            tick();
        end
        id_ready = 1'b1;
        #1;
        check("t3 freeze release", fetch_freeze, 0);
        tick();
        check("t3 xfers", d_xfers - x0, 1);

        // Branch while waiting: request is dropped, refetch from the new pc
        x0 = d_xfers;
        tick();
        check("t4 mem_addr", mem.mem_addr, 32'hC);
        branch_taken = 1'b1; br_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        check("t4 drop req held", mem.mem_req, 1);
        check("t4 drop addr held", mem.mem_addr, 32'hC);
        tick();
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem.mem_ack = 1'b0;
        check("t4 no valid after drop", instr_valid, 0);
        check("t4 req dropped", mem.mem_req, 0);
        tick();
        check("t4 new req addr", mem.mem_addr, 32'h100);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h1111_1111;
        tick();
        mem.mem_ack = 1'b0;
        check("t4 instr", instr_out, 32'h1111_1111);
        check("t4 pc_out", pc_out, 32'h104);
        tick();
        check("t4 xfers", d_xfers - x0, 1);

        // Branch coinciding with ack, then branch while VALID with id_ready
        x0 = d_xfers;
        tick();
        check("t5 mem_addr", mem.mem_addr, 32'h104);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'hDEAD_BEEF; branch_taken = 1'b1; br_target = 32'h200;
        tick();
        mem.mem_ack = 1'b0; branch_taken = 1'b0;
        check("t5 ack+branch no valid", instr_valid, 0);
        check("t5 ack+branch req", mem.mem_req, 0);
        tick();
        check("t5 req addr", mem.mem_addr, 32'h200);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h2222_2222;
        tick();
        mem.mem_ack = 1'b0;
        branch_taken = 1'b1; br_target = 32'h300;
        #1;
        check("t5 freeze on branch", fetch_freeze, 1);
        tick();
        branch_taken = 1'b0;
        check("t5 valid cleared", instr_valid, 0);
        check("t5 xfers", d_xfers - x0, 0);

        // Timeout with TIMEOUT=4, then reset in the middle of a wait
        tick();
        check("t6 addr", mem.mem_addr, 32'h300);
        check("t6 err W1", fetch_err, 0);
        tick(); tick(); tick();
        check("t6 err W4", fetch_err, 0);
        tick();
        check("t6 err W5", fetch_err, 1);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h3333_3333;
        tick();
        mem.mem_ack = 1'b0;
        check("t6 err after ack", fetch_err, 1);
        check("t6 valid after ack", instr_valid, 1);
        tick();
        check("t6 err sticky", fetch_err, 1);
        tick();
        check("t6 req before rst", mem.mem_req, 1);
        rst = 1'b1;
        tick();
        check("t6 rst mem_req", mem.mem_req, 0);
        check("t6 rst mem_addr", mem.mem_addr, 0);
        check("t6 rst valid", instr_valid, 0);
        check("t6 rst instr", instr_out, 0);
        check("t6 rst pc_out", pc_out, 0);
        check("t6 rst err", fetch_err, 0);
        rst = 1'b0;
        tick();
        check("t6 recover addr", mem.mem_addr, 32'h304);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h4444_4444;
        tick();
        mem.mem_ack = 1'b0;
        check("t6 recover pc_out", pc_out, 32'h308);
        tick();

        // Ack in IDLE is ignored; pc_out wraps at the top of the address space
        branch_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h9999_9999;
        tick();
        branch_taken = 1'b0; mem.mem_ack = 1'b0;
        check("t7 idle ack ignored valid", instr_valid, 0);
        check("t7 idle ack ignored req", mem.mem_req, 0);
        tick();
        check("t7 wrap addr", mem.mem_addr, 32'hFFFF_FFFC);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h5555_5555;
        tick();
        mem.mem_ack = 1'b0;
        check("t7 wrap pc_out", pc_out, 32'h0);
        check("t7 wrap instr", instr_out, 32'h5555_5555);
        tick();

        check("total xfers", d_xfers, m_xfers);
        check("total xfers literal", d_xfers, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
